alu_share_arbiter: RTL
======================

# alu_share_arbiter

Two-requester arbiter that shares one 32-bit ALU between independent clients, e.g. the main execute datapath and a branch/address-calculation unit. It accepts operation requests over valid/ready handshakes and grants one per cycle, round-robin on conflict. It drives the ALU and registers the result, zero flag and requester ID into a single response slot with its own valid/ready handshake.

## Interface
- DATA_WIDTH, 32, operand/result width
- OP_WIDTH, 4, ALU operation code width
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- req0_valid  input  1  requester 0 presents an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_op  input  OP_WIDTH  requester 0 ALU operation code
- req0_a, req0_b  input  DATA_WIDTH  requester 0 operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- rsp_valid  output  1  response slot holds a result
- rsp_ready  input  1  consumer takes the response this cycle
- rsp_id  output  1  requester that issued the response (0/1)
- rsp_result  output  DATA_WIDTH  registered ALU result
- rsp_zero  output  1  registered result == 0
- rsp_illegal  output  1  op code was not a legal operation

## Operation
- Legal op codes: AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100, XOR 0101, WORD 0110 (A + (B<<2)), LUI 1010 ({B[15:0],16'h0}). All arithmetic is modulo 2^DATA_WIDTH with no carry or overflow output.
- Illegal op codes: result 0, rsp_zero=1, rsp_illegal=1. Legal op codes give rsp_illegal=0.
- slot_free = !rsp_valid | rsp_ready.
- Priority pointer prio (1 bit). When both requesters are valid and the slot is free, grant requester prio, then set prio to the other requester. A lone valid requester is granted regardless of prio, and prio flips to the other requester.
- req0_ready = slot_free & reset & (!req1_valid | prio==0). req1_ready is symmetric with prio==1. Ready is combinational; it never depends on the requester's own valid.
- Transfer occurs on reqN_valid & reqN_ready. At most one transfer per cycle.
- On transfer, the ALU is fed the granted op/A/B through a mux. The result, zero, illegal and ID are captured into the response register and rsp_valid is set.
- No transfer & rsp_ready & rsp_valid: rsp_valid clears.
- State is implicit: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY -> FULL on a transfer.
  - FULL -> EMPTY on drain without a new transfer.
  - FULL -> FULL on drain plus a simultaneous new transfer (back-to-back).

## Timing
- Reset (reset=0 at a clock edge): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_illegal=0, prio=0. Both readies are 0 while reset=0.
- Reset mid-operation discards any pending response. Requesters must re-issue.
- Latency: request accepted at edge N; response visible after edge N, stable until the edge where rsp_ready=1.
- Throughput: 1 op/cycle when rsp_ready is held high.
- Backpressure: with rsp_valid=1 and rsp_ready=0, both readies are 0 and all rsp_* outputs are held constant.
- Requester inputs are sampled only on the transfer edge. They may change freely otherwise.

## Structure
- Shared package alu_pkg: OP_WIDTH, DATA_WIDTH and the eight op-code constants (AND … LUI). Both the ALU and this block import it.
- Sub-module: the team ALU, instanced once, fed from the grant mux. Illegal-op detection is done locally from alu_pkg constants.
- Arbitration, response register and handshake logic are in-line. No further sub-modules.

## Test plan
- Reset held 3 cycles with both requesters valid -> readies 0 throughout, all rsp_* 0. First grant after release goes to req0.
- req0 only, ADD A=5 B=7, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0. Then ADD 0xFFFFFFFF+1 -> result 0, zero=1.
- Both requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,0,1. req1 SUB 9-9 -> result 0, zero=1.
- Backpressure: rsp_ready=0 for 3 cycles after a grant -> rsp_* stable, no transfers. rsp_ready=1 -> drain and new grant on the same edge, rsp_valid stays 1.
- Op coverage:
  - LUI B=0x0000ABCD -> 0xABCD0000.
  - WORD A=0x100 B=3 -> 0x10C.
  - NOR 0,0 -> 0xFFFFFFFF.
  - Op 4'b1111 -> result 0, zero=1, illegal=1.
- Reset while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0 after the edge, prio back to 0, the held result is lost.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths and operation codes
package alu_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int OP_WIDTH = 4;
  localparam logic [OP_WIDTH-1:0] OP_AND  = 4'b0000;
  localparam logic [OP_WIDTH-1:0] OP_OR   = 4'b0001;
  localparam logic [OP_WIDTH-1:0] OP_NOR  = 4'b0010;
  localparam logic [OP_WIDTH-1:0] OP_ADD  = 4'b0011;
  localparam logic [OP_WIDTH-1:0] OP_SUB  = 4'b0100;
  localparam logic [OP_WIDTH-1:0] OP_XOR  = 4'b0101;
  localparam logic [OP_WIDTH-1:0] OP_WORD = 4'b0110;
  localparam logic [OP_WIDTH-1:0] OP_LUI  = 4'b1010;
endpackage

// File: rtl/alu_share_arbiter_alu.sv
// alu_share_arbiter_alu: combinational 32-bit team ALU, unknown ops yield 0
module alu_share_arbiter_alu
  import alu_pkg::*;
(
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_XOR:  y = a ^ b;
      OP_WORD: y = a + (b << 2);
      OP_LUI:  y = {b[15:0], 16'h0};
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two requesters
module alu_share_arbiter
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [OP_WIDTH-1:0]   req0_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [OP_WIDTH-1:0]   req1_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_illegal
);
  logic prio;
  logic slot_free;
  logic xfer0;
  logic xfer1;
  logic illegal;
  logic [OP_WIDTH-1:0] op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] y;
  assign slot_free = !rsp_valid | rsp_ready;
  // each ready excludes the other requester only when it is competing and holds priority
  assign req0_ready = slot_free & reset & (!req1_valid | !prio);
  assign req1_ready = slot_free & reset & (!req0_valid | prio);
  assign xfer0 = req0_valid & req0_ready;
  assign xfer1 = req1_valid & req1_ready;
  assign op = xfer1 ? req1_op : req0_op;
  assign a = xfer1 ? req1_a : req0_a;
  assign b = xfer1 ? req1_b : req0_b;
  assign illegal = !(op inside {OP_AND, OP_OR, OP_NOR, OP_ADD, OP_SUB, OP_XOR, OP_WORD, OP_LUI});
  alu_share_arbiter_alu u_alu (
    .op(op),
    .a (a),
    .b (b),
    .y (y)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
      prio        <= 1'b0;
    end else if (xfer0 | xfer1) begin
      rsp_valid   <= 1'b1;
      rsp_id      <= xfer1;
      rsp_result  <= illegal ? '0 : y;
      rsp_zero    <= illegal | (y == '0);
      rsp_illegal <= illegal;
      prio        <= !xfer1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule
